// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer: entry-point launch, conditional relative branches, stall, halt.
// Optional return-address stack enabled by defining PC_CALL_STACK_EN.
module pc_seq_ctrl #(
  parameter int PC_W        = 10,
  parameter int BAMT_W      = 10,
  parameter int NUM_PROGS   = 3,
  parameter logic [NUM_PROGS*PC_W-1:0] PROG_BASE = {10'd44, 10'd25, 10'd0},
  parameter int STACK_DEPTH = 4,
  localparam int SEL_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [SEL_W-1:0]  prog_sel_i,
  input  logic              stall_i,
  input  logic [2:0]        br_type_i,
  input  logic              z_i,
  input  logic              lt_i,
  input  logic [BAMT_W-1:0] bamt_i,
  output logic [PC_W-1:0]   pc_o,
  output logic              running_o,
  output logic              done_o,
  output logic              stack_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam logic [2:0] BR_NOP  = 3'd0;
  localparam logic [2:0] BR_BA   = 3'd1;
  localparam logic [2:0] BR_BL   = 3'd2;
  localparam logic [2:0] BR_BG   = 3'd3;
  localparam logic [2:0] BR_BE   = 3'd4;
  localparam logic [2:0] BR_CALL = 3'd5;
  localparam logic [2:0] BR_RET  = 3'd6;
  localparam logic [2:0] BR_HALT = 3'd7;

  localparam logic [SEL_W:0] NUM_PROGS_L = (SEL_W+1)'(NUM_PROGS);

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  pc_inc, pc_br;
  logic [PC_W-1:0]  entry_tbl [NUM_PROGS];
  logic             start_ok;

  for (genvar g = 0; g < NUM_PROGS; g++) begin : g_entry
    assign entry_tbl[g] = PROG_BASE[g*PC_W +: PC_W];
  end

  // Size cast of a signed operand sign-extends the offset to PC_W.
  assign pc_inc   = pc_q + PC_W'(1);
  assign pc_br    = pc_q + PC_W'($signed(bamt_i));
  assign start_ok = start_i && ({1'b0, prog_sel_i} < NUM_PROGS_L);

`ifdef PC_CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SP_W-1:0]  sp_q, sp_d;
  logic             err_q, err_d;
  logic             push_en;
  logic [PC_W-1:0]  stack_q [STACK_DEPTH];
  logic [PC_W-1:0]  stack_top;

  assign stack_top = stack_q[IDX_W'(sp_q - SP_W'(1))];

  always_ff @(posedge clk) begin
    if (push_en) stack_q[IDX_W'(sp_q)] <= pc_inc;
  end
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_CALL_STACK_EN
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;
`endif
    if (start_ok) begin
      pc_d    = entry_tbl[prog_sel_i];
      state_d = S_RUN;
`ifdef PC_CALL_STACK_EN
      sp_d    = '0;
      err_d   = 1'b0;
`endif
    end else if (state_q == S_RUN && !stall_i) begin
      pc_d = pc_inc;
      unique case (br_type_i)
        BR_BA:   pc_d = pc_br;
        BR_BL:   if (lt_i)  pc_d = pc_br;
        BR_BG:   if (!lt_i) pc_d = pc_br;
        BR_BE:   if (z_i)   pc_d = pc_br;
        BR_HALT: begin
          pc_d    = pc_q;
          state_d = S_HALT;
        end
`ifdef PC_CALL_STACK_EN
        BR_CALL: begin
          if (sp_q == SP_W'(STACK_DEPTH)) begin
            pc_d    = pc_q;
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d    = pc_br;
            push_en = 1'b1;
            sp_d    = sp_q + SP_W'(1);
          end
        end
        BR_RET: begin
          if (sp_q == '0) begin
            pc_d    = pc_q;
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d = stack_top;
            sp_d = sp_q - SP_W'(1);
          end
        end
`else
        // Without the stack, CALL degenerates to an always-taken branch.
        BR_CALL: pc_d = pc_br;
        BR_RET:  pc_d = pc_inc;
`endif
        BR_NOP:  pc_d = pc_inc;
        default: pc_d = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
`ifdef PC_CALL_STACK_EN
      sp_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef PC_CALL_STACK_EN
      sp_q    <= sp_d;
      err_q   <= err_d;
`endif
    end
  end

  assign pc_o      = pc_q;
  assign running_o = (state_q == S_RUN);
  assign done_o    = (state_q == S_HALT);
`ifdef PC_CALL_STACK_EN
  assign stack_err_o = err_q;
`else
  assign stack_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed self-checking bench for pc_seq_ctrl; observation word is {pc, running, done, stack_err}.
module tb_pc_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] prog_sel;
  logic       stall;
  logic [2:0] br_type;
  logic       z, lt;
  logic [9:0] bamt;
  logic [9:0] pc;
  logic       running, done, stack_err;

  logic [12:0] obs, exp;
  int chk_cnt  = 0;
  int pass_cnt = 0;

  assign obs = {pc, running, done, stack_err};

  always #5 clk = ~clk;

  pc_seq_ctrl dut (
    .clk(clk), .reset(reset), .start_i(start), .prog_sel_i(prog_sel), .stall_i(stall),
    .br_type_i(br_type), .z_i(z), .lt_i(lt), .bamt_i(bamt),
    .pc_o(pc), .running_o(running), .done_o(done), .stack_err_o(stack_err)
  );

  task automatic cyc(input logic s, input logic [1:0] sel, input logic stl, input logic [2:0] br,
                     input logic zz, input logic ll, input logic [9:0] amt);
    start = s; prog_sel = sel; stall = stl; br_type = br; z = zz; lt = ll; bamt = amt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp = {10'd0, 3'b000}; chk_cnt++;
    if (obs !== exp) $display("FAIL reset_state: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    cyc(0, 0, 0, 3'd1, 0, 0, 10'd5);
    exp = {10'd0, 3'b000}; chk_cnt++;
    if (obs !== exp) $display("FAIL idle_ignores_br: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
  endtask

  task automatic test_start();
    cyc(1, 2'd1, 0, 3'd0, 0, 0, 10'd0);
    exp = {10'd25, 3'b100}; chk_cnt++;
    if (obs !== exp) $display("FAIL start_prog1: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 0, 3'd0, 0, 0, 10'd0);
      exp = {10'(25 + i), 3'b100}; chk_cnt++;
      if (obs !== exp) $display("FAIL nop_step%0d: got pc=%0d rde=%b want pc=%0d rde=%b", i, obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    cyc(0, 0, 0, 3'd0, 0, 0, 10'd0);
    cyc(0, 0, 0, 3'd0, 0, 0, 10'd0);
    exp = {10'd30, 3'b100}; chk_cnt++;
    if (obs !== exp) $display("FAIL pre_reset_pc30: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    exp = {10'd0, 3'b000}; chk_cnt++;
    if (obs !== exp) $display("FAIL async_reset: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    #2 reset = 1'b0;
    cyc(0, 0, 0, 3'd0, 0, 0, 10'd0);
    exp = {10'd0, 3'b000}; chk_cnt++;
    if (obs !== exp) $display("FAIL post_reset_idle: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
  endtask

  task automatic test_branch();
    cyc(1, 2'd2, 0, 3'd0, 0, 0, 10'd0);
    exp = {10'd44, 3'b100}; chk_cnt++;
    if (obs !== exp) $display("FAIL start_prog2: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    cyc(0, 0, 0, 3'd1, 0, 0, 10'h3FC);
    exp = {10'd40, 3'b100}; chk_cnt++;
    if (obs !== exp) $display("FAIL ba_minus4: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    cyc(0, 0, 0, 3'd2, 0, 1, 10'h3FB);
    exp = {10'd35, 3'b100}; chk_cnt++;
    if (obs !== exp) $display("FAIL bl_taken: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    cyc(0, 0, 0, 3'd3, 0, 1, 10'h3FB);
    exp = {10'd36, 3'b100}; chk_cnt++;
    if (obs !== exp) $display("FAIL bg_not_taken: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    cyc(0, 0, 0, 3'd4, 1, 0, 10'd3);
    exp = {10'd39, 3'b100}; chk_cnt++;
    if (obs !== exp) $display("FAIL be_taken: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    cyc(0, 0, 0, 3'd4, 0, 0, 10'd3);
    exp = {10'd40, 3'b100}; chk_cnt++;
    if (obs !== exp) $display("FAIL be_not_taken: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
  endtask

  task automatic test_stall_start();
    cyc(1, 2'd0, 0, 3'd0, 0, 0, 10'd0);
    cyc(0, 0, 0, 3'd1, 0, 0, 10'd10);
    exp = {10'd10, 3'b100}; chk_cnt++;
    if (obs !== exp) $display("FAIL ba_to_10: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 1, 3'd1, 0, 0, 10'd5);
      exp = {10'd10, 3'b100}; chk_cnt++;
      if (obs !== exp) $display("FAIL stall_hold%0d: got pc=%0d rde=%b want pc=%0d rde=%b", i, obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    end
    cyc(1, 2'd2, 1, 3'd1, 0, 0, 10'd5);
    exp = {10'd44, 3'b100}; chk_cnt++;
    if (obs !== exp) $display("FAIL start_beats_stall: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
  endtask

  task automatic test_wrap();
    cyc(1, 2'd0, 0, 3'd0, 0, 0, 10'd0);
    cyc(0, 0, 0, 3'd1, 0, 0, 10'h3FF);
    exp = {10'd1023, 3'b100}; chk_cnt++;
    if (obs !== exp) $display("FAIL wrap_to_1023: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    cyc(0, 0, 0, 3'd0, 0, 0, 10'd0);
    exp = {10'd0, 3'b100}; chk_cnt++;
    if (obs !== exp) $display("FAIL wrap_inc: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    cyc(0, 0, 0, 3'd0, 0, 0, 10'd0);
    cyc(0, 0, 0, 3'd0, 0, 0, 10'd0);
    cyc(0, 0, 0, 3'd1, 0, 0, 10'h3FC);
    exp = {10'd1022, 3'b100}; chk_cnt++;
    if (obs !== exp) $display("FAIL wrap_back: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
  endtask

  task automatic test_halt();
    cyc(1, 2'd1, 0, 3'd0, 0, 0, 10'd0);
    cyc(0, 0, 0, 3'd0, 0, 0, 10'd0);
    cyc(0, 0, 0, 3'd7, 0, 0, 10'd9);
    exp = {10'd26, 3'b010}; chk_cnt++;
    if (obs !== exp) $display("FAIL halt_done: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    cyc(0, 0, 0, 3'd1, 0, 0, 10'd9);
    exp = {10'd26, 3'b010}; chk_cnt++;
    if (obs !== exp) $display("FAIL halt_ignores_br: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    cyc(1, 2'd3, 0, 3'd0, 0, 0, 10'd0);
    exp = {10'd26, 3'b010}; chk_cnt++;
    if (obs !== exp) $display("FAIL bad_sel_ignored: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    cyc(1, 2'd0, 0, 3'd0, 0, 0, 10'd0);
    exp = {10'd0, 3'b100}; chk_cnt++;
    if (obs !== exp) $display("FAIL restart_from_halt: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
  endtask

  task automatic test_call_ret();
    cyc(1, 2'd0, 0, 3'd0, 0, 0, 10'd0);
    cyc(0, 0, 0, 3'd1, 0, 0, 10'd5);
    cyc(0, 0, 0, 3'd5, 0, 0, 10'd10);
    exp = {10'd15, 3'b100}; chk_cnt++;
    if (obs !== exp) $display("FAIL call_target: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    cyc(0, 0, 0, 3'd6, 0, 0, 10'd0);
`ifdef PC_CALL_STACK_EN
    exp = {10'd6, 3'b100}; chk_cnt++;
    if (obs !== exp) $display("FAIL ret_target: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 3'd5, 0, 0, 10'd1);
    exp = {10'd10, 3'b100}; chk_cnt++;
    if (obs !== exp) $display("FAIL nested_call4: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    cyc(0, 0, 0, 3'd5, 0, 0, 10'd1);
    exp = {10'd10, 3'b011}; chk_cnt++;
    if (obs !== exp) $display("FAIL stack_overflow: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    cyc(1, 2'd0, 0, 3'd0, 0, 0, 10'd0);
    exp = {10'd0, 3'b100}; chk_cnt++;
    if (obs !== exp) $display("FAIL err_cleared: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    cyc(0, 0, 0, 3'd6, 0, 0, 10'd0);
    exp = {10'd0, 3'b011}; chk_cnt++;
    if (obs !== exp) $display("FAIL stack_underflow: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
`else
    exp = {10'd16, 3'b100}; chk_cnt++;
    if (obs !== exp) $display("FAIL ret_as_nop: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
    cyc(0, 0, 0, 3'd6, 0, 0, 10'd0);
    exp = {10'd17, 3'b100}; chk_cnt++;
    if (obs !== exp) $display("FAIL ret_no_err: got pc=%0d rde=%b want pc=%0d rde=%b", obs[12:3], obs[2:0], exp[12:3], exp[2:0]); else pass_cnt++;
`endif
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; prog_sel = '0; stall = 1'b0;
    br_type = '0; z = 1'b0; lt = 1'b0; bamt = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_start();
    test_async_reset();
    test_branch();
    test_stall_start();
    test_wrap();
    test_halt();
    test_call_ret();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
